// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the radix-2 DIT FFT controller
package fft_pkg;
  localparam int L = 11;
  localparam int N = 1 << L;
  localparam int PIPE = 3;
  typedef logic [L-1:0] adr_t;
  typedef logic [L-2:0] tw_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/fft_if.sv
// fft_if: control and address bus between the FFT controller and its datapath/sample banks
interface fft_if #(parameter int STAGES = fft_pkg::L);
  logic start, busy, done, rd_en, rd_bank, wr_en, wr_bank, result_bank;
  logic [$clog2(STAGES)-1:0] stage;
  logic [STAGES-1:0] rd_adr_a, rd_adr_b, wr_adr_a, wr_adr_b;
  logic [STAGES-2:0] tw_adr;
  modport master (
    output start,
    input busy, done, stage, rd_en, rd_adr_a, rd_adr_b, tw_adr, rd_bank,
    input wr_en, wr_adr_a, wr_adr_b, wr_bank, result_bank
  );
  modport slave (
    input start,
    output busy, done, stage, rd_en, rd_adr_a, rd_adr_b, tw_adr, rd_bank,
    output wr_en, wr_adr_a, wr_adr_b, wr_bank, result_bank
  );
endinterface

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: butterfly (stage s, index j) -> operand addresses and twiddle index
module fft_addr_gen import fft_pkg::*; #(
  parameter int STAGES = L
) (
  input  logic [$clog2(STAGES)-1:0] s,
  input  logic [STAGES-2:0]         j,
  output logic [STAGES-1:0]         adr_a,
  output logic [STAGES-1:0]         adr_b,
  output logic [STAGES-2:0]         tw
);
  logic [STAGES-1:0] ea, eb;
  logic [STAGES-2:0] ones;
  assign ea = {j, 1'b0};
  assign eb = {j, 1'b1};
  assign ones = '1;
  // rotate left by s within STAGES bits
  assign adr_a = (ea << s) | (ea >> (STAGES - s));
  assign adr_b = (eb << s) | (eb >> (STAGES - s));
  assign tw = j & (ones << (STAGES - 1 - s));
endmodule

// File: rtl/fft_ctrl.sv
// fft_ctrl: stage/butterfly sequencer with read and delayed write-back address generation
module fft_ctrl import fft_pkg::*; #(
  parameter int STAGES = L,
  parameter int LAT = PIPE
) (
  input logic clk,
  input logic reset,
  fft_if.slave bus
);
  localparam int SW = $clog2(STAGES);
  typedef struct packed {
    logic en;
    logic [STAGES-1:0] a;
    logic [STAGES-1:0] b;
    logic bank;
  } wb_t;
  state_t st, st_n;
  logic [SW-1:0] s, s_n;
  logic [STAGES-2:0] j, j_n;
  logic [3:0] cnt, cnt_n;
  logic [STAGES-1:0] a_n, b_n;
  logic [STAGES-2:0] tw_n;
  logic last_s;
  wb_t dly [LAT];

  assign last_s = s == SW'(STAGES - 1);

  fft_addr_gen #(.STAGES(STAGES)) u_gen (.s(s_n), .j(j_n), .adr_a(a_n), .adr_b(b_n), .tw(tw_n));

  always_comb begin
    st_n = st;
    s_n = s;
    j_n = j;
    cnt_n = cnt;
    case (st)
      IDLE: if (bus.start) begin
        st_n = RUN;
        s_n = '0;
        j_n = '0;
      end
      RUN: if (&j) begin
        st_n = DRAIN;
        cnt_n = '0;
      end else j_n = j + 1'b1;
      DRAIN: begin
        cnt_n = cnt + 1'b1;
        if (cnt == 4'(LAT - 1)) begin
          st_n = last_s ? DONE : RUN;
          s_n = last_s ? s : s + 1'b1;
          j_n = '0;
        end
      end
      default: begin
        st_n = IDLE;
        s_n = '0;
        j_n = '0;
      end
    endcase
  end

  // outputs are registered from next-state values so they line up with st/s/j
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      s <= '0;
      j <= '0;
      cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.stage <= '0;
      bus.rd_en <= 1'b0;
      bus.rd_adr_a <= '0;
      bus.rd_adr_b <= '0;
      bus.tw_adr <= '0;
      bus.rd_bank <= 1'b0;
      dly <= '{default: '0};
    end else begin
      st <= st_n;
      s <= s_n;
      j <= j_n;
      cnt <= cnt_n;
      bus.busy <= st_n != IDLE;
      bus.done <= st_n == DONE;
      bus.stage <= s_n;
      bus.rd_en <= st_n == RUN;
      bus.rd_adr_a <= (st_n == RUN) ? a_n : '0;
      bus.rd_adr_b <= (st_n == RUN) ? b_n : '0;
      bus.tw_adr <= (st_n == RUN) ? tw_n : '0;
      bus.rd_bank <= s_n[0];
      dly[0] <= {bus.rd_en, bus.rd_adr_a, bus.rd_adr_b, bus.rd_en & ~bus.rd_bank};
      for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign {bus.wr_en, bus.wr_adr_a, bus.wr_adr_b, bus.wr_bank} = dly[LAT-1];
  assign bus.result_bank = 1'(STAGES % 2);
endmodule
